// File: rtl/q2_pkg.sv
// q2_pkg: shared types and constants for the Q2 control sequencer.
//   state_t  - encoded top-level sequencer state (driven on the state port)
//   xsel_t   - source select for the high bits of the X register
//   hact_t   - front-panel action in progress while sitting in HALT
//   OP_*     - opcode values of the non-ALU instructions
//   is_alu() - true for the 0xx opcode group
package q2_pkg;

  typedef enum logic [2:0] {
    HALT  = 3'd0,
    FETCH = 3'd1,
    DEREF = 3'd2,
    EXEC  = 3'd3,
    ALU   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    PAGE_P = 2'd1,
    DBUS   = 2'd2
  } xsel_t;

  typedef enum logic [1:0] {
    HA_IDLE    = 2'd0,
    HA_DEP_WM  = 2'd1,
    HA_DEP_INC = 2'd2,
    HA_INC     = 2'd3
  } hact_t;

  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_JMP   = 3'b110;
  localparam logic [2:0] OP_JNF   = 3'b111;

  function automatic logic is_alu(input logic [2:0] o);
    return (o & 3'b100) == 3'b000;
  endfunction

endpackage

// File: rtl/q2_edge_detect.sv
// q2_edge_detect: registers an N-bit group of already-debounced levels and
// flags single-cycle rising edges on each bit.
//   clk, rst_n - system clock, synchronous active-low reset
//   d          - raw input levels
//   level      - registered copy of d
//   rise       - one-cycle pulse when level goes 0 -> 1
// Reset clears both the level and its history, so the first cycle after
// reset never shows an edge.
module q2_edge_detect #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] level,
  output logic [N-1:0] rise
);

  logic [N-1:0] prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= '0;
      prev  <= '0;
    end else begin
      level <= d;
      prev  <= level;
    end
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/q2_sequencer.sv
// q2_sequencer: control sequencer for the Q2 CPU datapath.
//   clk, rst_n                  - system clock, synchronous active-low reset
//   run_sw/step_sw/dep_sw/incp_sw - debounced front-panel switch levels
//   op, deref                   - opcode and indirect bit of current instruction
//   dbus_msb                    - data bus MSB, selects X-high source in FETCH
//   flag                        - F flag, gates the conditional jump
//   alu_cout                    - serial ALU result bit, inverted into f_in
//   state, ws                   - encoded state and write-strobe phase
//   rd_p..f_in                  - datapath strobes
//   x_hi_sel                    - X-high source (ZERO / PAGE_P / DBUS)
//   halted                      - sequencer idle in HALT
//
// state | meaning
// ------+-----------------------------------------------------------------
// HALT  | idle; services run/step/deposit/increment switch edges
// FETCH | read instruction at P; ws: load O and X, increment P
// DEREF | indirect: read word at X back into X (ws)
// EXEC  | load / store / jump strobes in ws
// ALU   | DATA_W bit-serial shift cycles, result written on the last one
module q2_sequencer
  import q2_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_sw,
  input  logic       step_sw,
  input  logic       dep_sw,
  input  logic       incp_sw,
  input  logic [2:0] op,
  input  logic       deref,
  input  logic       dbus_msb,
  input  logic       flag,
  input  logic       alu_cout,
  output logic [2:0] state,
  output logic       ws,
  output logic       rd_p,
  output logic       wr_o,
  output logic       wr_x,
  output logic       rd_x,
  output logic       x_shift,
  output logic [1:0] x_hi_sel,
  output logic       wr_p,
  output logic       inc_p,
  output logic       wr_m,
  output logic       wr_a,
  output logic       wr_f,
  output logic       f_in,
  output logic       halted
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

  // Switch synchroniser / edge detector; bit order run, step, dep, incp.
  logic [3:0] sw_lvl;
  logic [3:0] sw_rise;
  logic       unused_sw_lvl;

  q2_edge_detect #(.N(4)) u_sw_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({incp_sw, dep_sw, step_sw, run_sw}),
    .level (sw_lvl),
    .rise  (sw_rise)
  );

  // Only the run level matters (for the end-of-instruction decision).
  assign unused_sw_lvl = ^sw_lvl[3:1];

  logic run_lvl;
  logic rise_run, rise_step, rise_dep, rise_incp;

  assign run_lvl   = sw_lvl[0];
  assign rise_run  = sw_rise[0];
  assign rise_step = sw_rise[1];
  assign rise_dep  = sw_rise[2];
  assign rise_incp = sw_rise[3];

  state_t           st, st_n;
  logic             phase, phase_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  hact_t            hact, hact_n;
  logic             step_mode, step_mode_n;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= HALT;
      phase     <= 1'b0;
      cnt       <= '0;
      hact      <= HA_IDLE;
      step_mode <= 1'b0;
    end else begin
      st        <= st_n;
      phase     <= phase_n;
      cnt       <= cnt_n;
      hact      <= hact_n;
      step_mode <= step_mode_n;
    end
  end

  // Next-state logic
  always_comb begin
    logic end_instr;
    st_n        = st;
    phase_n     = phase;
    cnt_n       = cnt;
    hact_n      = hact;
    step_mode_n = step_mode;
    end_instr   = 1'b0;

    unique case (st)
      HALT: begin
        phase_n = 1'b0;
        cnt_n   = '0;
        // A panel action runs to completion; edges arriving meanwhile are
        // not queued.
        if (hact != HA_IDLE) begin
          hact_n = (hact == HA_DEP_WM) ? HA_DEP_INC : HA_IDLE;
        end else if (rise_run || rise_step) begin
          st_n        = FETCH;
          step_mode_n = !rise_run;
        end else if (rise_dep) begin
          hact_n = HA_DEP_WM;   // deposit beats a simultaneous incp edge
        end else if (rise_incp) begin
          hact_n = HA_INC;
        end
      end

      FETCH: begin
        phase_n = !phase;
        if (phase) st_n = deref ? DEREF : EXEC;
      end

      DEREF: begin
        phase_n = !phase;
        if (phase) st_n = EXEC;
      end

      EXEC: begin
        phase_n = !phase;
        if (phase) begin
          if (is_alu(op)) begin
            st_n  = ALU;
            cnt_n = '0;
          end else begin
            end_instr = 1'b1;
          end
        end
      end

      ALU: begin
        phase_n = 1'b0;
        if (cnt == CNT_MAX) begin
          cnt_n     = '0;
          end_instr = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: begin
        st_n    = HALT;
        phase_n = 1'b0;
        cnt_n   = '0;
        hact_n  = HA_IDLE;
      end
    endcase

    // A stepped instruction always returns to HALT, even with run held.
    if (end_instr) begin
      st_n        = (run_lvl && !step_mode) ? FETCH : HALT;
      step_mode_n = 1'b0;
    end
  end

  // Output decode
  always_comb begin
    rd_p     = 1'b0;
    wr_o     = 1'b0;
    wr_x     = 1'b0;
    rd_x     = 1'b0;
    x_shift  = 1'b0;
    x_hi_sel = ZERO;
    wr_p     = 1'b0;
    inc_p    = 1'b0;
    wr_m     = 1'b0;
    wr_a     = 1'b0;
    wr_f     = 1'b0;
    f_in     = 1'b0;
    halted   = 1'b0;

    unique case (st)
      HALT: begin
        halted = 1'b1;
        wr_m   = (hact == HA_DEP_WM);
        inc_p  = (hact == HA_DEP_INC) || (hact == HA_INC);
      end

      FETCH: begin
        rd_p     = 1'b1;
        x_hi_sel = dbus_msb ? PAGE_P : ZERO;
        wr_o     = phase;
        wr_x     = phase;
        inc_p    = phase;
      end

      DEREF: begin
        rd_x     = 1'b1;
        x_hi_sel = DBUS;
        wr_x     = phase;
      end

      EXEC: begin
        rd_x = 1'b1;
        if (phase) begin
          unique case (op)
            OP_LOAD:  wr_a = 1'b1;
            OP_STORE: wr_m = 1'b1;
            OP_JMP:   wr_p = 1'b1;
            OP_JNF:   wr_p = !flag;
            default:  ;
          endcase
        end
      end

      ALU: begin
        x_shift = 1'b1;
        if (cnt == CNT_MAX) begin
          wr_a = 1'b1;
          wr_f = 1'b1;
          f_in = !alu_cout;
        end
      end

      default: ;
    endcase
  end

  assign state = st;
  assign ws    = phase;

endmodule

// File: tb/tb_q2_sequencer.sv
module tb_q2_sequencer;
  import q2_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, run_sw, step_sw, dep_sw, incp_sw;
  logic [2:0] op;
  logic       deref, dbus_msb, flag, alu_cout;
  logic [2:0] state;
  logic       ws, rd_p, wr_o, wr_x, rd_x, x_shift;
  logic [1:0] x_hi_sel;
  logic       wr_p, inc_p, wr_m, wr_a, wr_f, f_in, halted;

  int n_cmp = 0;
  int n_bad = 0;

  q2_sequencer #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run_sw(run_sw), .step_sw(step_sw),
    .dep_sw(dep_sw), .incp_sw(incp_sw), .op(op), .deref(deref),
    .dbus_msb(dbus_msb), .flag(flag), .alu_cout(alu_cout),
    .state(state), .ws(ws), .rd_p(rd_p), .wr_o(wr_o), .wr_x(wr_x),
    .rd_x(rd_x), .x_shift(x_shift), .x_hi_sel(x_hi_sel), .wr_p(wr_p),
    .inc_p(inc_p), .wr_m(wr_m), .wr_a(wr_a), .wr_f(wr_f), .f_in(f_in),
    .halted(halted)
  );

  always #5 clk = ~clk;

  logic [12:0] strobes;
  assign strobes = {rd_p, wr_o, wr_x, rd_x, x_shift, x_hi_sel, wr_p,
                    inc_p, wr_m, wr_a, wr_f, f_in};

  typedef struct {
    string      name;
    logic [2:0] op;
    logic       deref, flag, cout;
    int         len, wra, wrm, wrp, xsh, wrf, fin, wrx, rdx;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [2:0] o,
                              input logic d, input logic f, input logic c,
                              input int len, input int wra, input int wrm,
                              input int wrp, input int xsh, input int wrf,
                              input int fin, input int wrx, input int rdx);
    vec_t v;
    v.name = nm; v.op = o; v.deref = d; v.flag = f; v.cout = c;
    v.len = len; v.wra = wra; v.wrm = wrm; v.wrp = wrp; v.xsh = xsh;
    v.wrf = wrf; v.fin = fin; v.wrx = wrx; v.rdx = rdx;
    return v;
  endfunction

  initial begin
    int len, c_wra, c_wrm, c_wrp, c_xsh, c_wrf, c_fin, c_wrx, c_rdx, nsh;

    //             name        op      d  f  c  len wra wrm wrp xsh wrf fin wrx rdx
    tbl[0] = mk("load",     3'b100, 0, 0, 0, 4,  1,  0,  0,  0,  0,  0,  1,  2);
    tbl[1] = mk("store_ind",3'b101, 1, 0, 0, 6,  0,  1,  0,  0,  0,  0,  2,  4);
    tbl[2] = mk("jmp",      3'b110, 0, 0, 0, 4,  0,  0,  1,  0,  0,  0,  1,  2);
    tbl[3] = mk("jnf_f1",   3'b111, 0, 1, 0, 4,  0,  0,  0,  0,  0,  0,  1,  2);
    tbl[4] = mk("jnf_f0",   3'b111, 0, 0, 0, 4,  0,  0,  1,  0,  0,  0,  1,  2);
    tbl[5] = mk("alu_ind",  3'b000, 1, 0, 0, 14, 1,  0,  0,  8,  1,  1,  2,  4);
    tbl[6] = mk("alu_c1",   3'b011, 0, 0, 1, 12, 1,  0,  0,  8,  1,  0,  1,  2);

    rst_n = 0; run_sw = 0; step_sw = 0; dep_sw = 0; incp_sw = 0;
    op = 3'b000; deref = 0; dbus_msb = 0; flag = 0; alu_cout = 0;

    // Reset then idle
    repeat (3) tick();
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_state", int'(state), int'(HALT));
      chk("idle_halted", int'(halted), 1);
      chk("idle_strobes", int'(strobes), 0);
    end

    // Run a load, cycle by cycle
    run_sw = 1; op = OP_LOAD; deref = 0; dbus_msb = 1;
    tick(); tick();
    chk("ld_c1_state", int'(state), int'(FETCH));
    chk("ld_c1_ws", int'(ws), 0);
    chk("ld_c1_rdp", int'(rd_p), 1);
    chk("ld_c1_xsel", int'(x_hi_sel), int'(PAGE_P));
    chk("ld_c1_wro", int'(wr_o), 0);
    tick();
    chk("ld_c2_ws", int'(ws), 1);
    chk("ld_c2_wro_wrx_incp", int'({wr_o, wr_x, inc_p}), 7);
    tick();
    chk("ld_c3_state", int'(state), int'(EXEC));
    chk("ld_c3_wra", int'(wr_a), 0);
    chk("ld_c3_rdx", int'(rd_x), 1);
    tick();
    chk("ld_c4_wra", int'(wr_a), 1);
    tick();
    chk("ld_c5_state", int'(state), int'(FETCH));
    chk("ld_c5_ws", int'(ws), 0);
    dbus_msb = 0;
    #1;
    chk("ld_c5_xsel_zero", int'(x_hi_sel), int'(ZERO));

    // Table-driven instructions, free running
    for (int k = 0; k < 7; k++) begin
      op = tbl[k].op; deref = tbl[k].deref; flag = tbl[k].flag;
      alu_cout = tbl[k].cout;
      len = 0; c_wra = 0; c_wrm = 0; c_wrp = 0; c_xsh = 0; c_wrf = 0;
      c_fin = 0; c_wrx = 0; c_rdx = 0;
      do begin
        c_wra += int'(wr_a); c_wrm += int'(wr_m); c_wrp += int'(wr_p);
        c_xsh += int'(x_shift); c_wrf += int'(wr_f); c_fin += int'(f_in);
        c_wrx += int'(wr_x); c_rdx += int'(rd_x);
        tick();
        len++;
      end while (!(state == FETCH && ws == 1'b0) && len < 40);
      chk({tbl[k].name, "_len"}, len, tbl[k].len);
      chk({tbl[k].name, "_wra"}, c_wra, tbl[k].wra);
      chk({tbl[k].name, "_wrm"}, c_wrm, tbl[k].wrm);
      chk({tbl[k].name, "_wrp"}, c_wrp, tbl[k].wrp);
      chk({tbl[k].name, "_xsh"}, c_xsh, tbl[k].xsh);
      chk({tbl[k].name, "_wrf"}, c_wrf, tbl[k].wrf);
      chk({tbl[k].name, "_fin"}, c_fin, tbl[k].fin);
      chk({tbl[k].name, "_wrx"}, c_wrx, tbl[k].wrx);
      chk({tbl[k].name, "_rdx"}, c_rdx, tbl[k].rdx);
    end

    // Dropping run finishes the current instruction, then halts
    run_sw = 0; op = OP_LOAD; deref = 0; flag = 0; alu_cout = 0;
    tick(); tick(); tick();
    chk("stop_not_yet", int'(halted), 0);
    tick();
    chk("stop_state", int'(state), int'(HALT));
    chk("stop_halted", int'(halted), 1);

    // Simultaneous deposit and incp edges
    dep_sw = 1; incp_sw = 1;
    tick(); tick();
    chk("dep_wrm", int'({wr_m, inc_p}), 2);
    tick();
    chk("dep_incp", int'({wr_m, inc_p}), 1);
    tick();
    chk("dep_done", int'({wr_m, inc_p}), 0);
    tick();
    chk("dep_no_2nd_incp", int'(inc_p), 0);
    chk("dep_halted", int'(halted), 1);
    dep_sw = 0; incp_sw = 0;
    tick(); tick();

    // incp alone
    incp_sw = 1;
    tick(); tick();
    chk("incp_pulse", int'({wr_m, inc_p}), 1);
    tick();
    chk("incp_single", int'(inc_p), 0);
    incp_sw = 0;
    tick(); tick();

    // Single step of a load
    step_sw = 1;
    tick(); tick();
    chk("step_fetch", int'(state), int'(FETCH));
    step_sw = 0;
    len = 0;
    while (!halted && len < 20) begin
      tick();
      len++;
    end
    chk("step_len", len, 4);
    repeat (5) tick();
    chk("step_stays_halt", int'(state), int'(HALT));

    // Reset in the middle of an ALU op
    op = 3'b000; deref = 0;
    step_sw = 1;
    tick(); tick();
    step_sw = 0;
    nsh = 0;
    for (int i = 0; i < 20 && nsh < 6; i++) begin
      tick();
      if (x_shift) nsh++;
    end
    chk("midalu_reached_cnt5", nsh, 6);
    rst_n = 0;
    tick();
    chk("rst_state", int'(state), int'(HALT));
    chk("rst_halted", int'(halted), 1);
    chk("rst_strobes", int'(strobes), 0);
    chk("rst_ws", int'(ws), 0);
    rst_n = 1;
    tick();
    chk("rst_no_edge", int'(state), int'(HALT));
    step_sw = 1;
    tick(); tick();
    step_sw = 0;
    len = 0; c_xsh = 0; c_wrf = 0;
    while (!halted && len < 40) begin
      c_xsh += int'(x_shift); c_wrf += int'(wr_f);
      tick();
      len++;
    end
    chk("rerun_len", len, 12);
    chk("rerun_xsh", c_xsh, 8);
    chk("rerun_wrf", c_wrf, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
